// File: rtl/galaga_shot_sched_pkg.sv
// Shared types and encodings for the two-ship shot scheduler.
package galaga_shot_sched_pkg;

   localparam int unsigned CNT_W  = 4;
   localparam int unsigned LIFE_W = 3;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_READY,
      ST_FLIGHT,
      ST_RESOLVE,
      ST_COOL,
      ST_OVER
   } state_e;

   localparam logic [1:0] POS_C   = 2'b00;
   localparam logic [1:0] POS_L   = 2'b01;
   localparam logic [1:0] POS_R   = 2'b10;
   localparam logic [1:0] POS_INV = 2'b11;

   localparam logic [1:0] WIN_NONE = 2'b00;
   localparam logic [1:0] WIN_S1   = 2'b01;
   localparam logic [1:0] WIN_S2   = 2'b10;

   // Aligned only when both positions agree and neither is the invalid code.
   function automatic logic pos_match(input logic [1:0] a, input logic [1:0] b);
      return (a == b) && (a != POS_INV);
   endfunction

endpackage

// File: rtl/galaga_shot_sched_fire_latch.sv
// Fire-button rising-edge detector with a single pending flag per ship.
module fire_latch (
   input  logic clk,
   input  logic rst,
   input  logic fire,
   input  logic en,
   input  logic clr,
   output logic pending
);

   logic fire_q;
   logic pend_q;
   logic pend_d;

   // Clear wins over a coincident edge; extra edges while pending are dropped.
   always_comb begin
      pend_d = pend_q;
      if (!en || clr) begin
         pend_d = 1'b0;
      end else if (fire && !fire_q) begin
         pend_d = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fire_q <= 1'b0;
         pend_q <= 1'b0;
      end else begin
         fire_q <= fire;
         pend_q <= pend_d;
      end
   end

   assign pending = pend_q;

endmodule

// File: rtl/galaga_shot_sched.sv
// Round sequencer: round-robin fire arbitration, shot flight timing,
// hit resolution against armor/lives, and winner declaration.
module galaga_shot_sched
   import galaga_shot_sched_pkg::*;
#(
   parameter int unsigned SHOT_CYCLES = 4,
   parameter int unsigned COOLDOWN    = 2,
   parameter int unsigned LIVES       = 3
) (
   input  logic       CLK,
   input  logic       RST,
   input  logic       START,
   input  logic       ARM_EN,
   input  logic       FIRE1,
   input  logic       FIRE2,
   input  logic [1:0] POS1,
   input  logic [1:0] POS2,
   output logic       SHOT1,
   output logic       SHOT2,
   output logic       HIT1,
   output logic       HIT2,
   output logic       A1,
   output logic       A2,
   output logic [2:0] P1,
   output logic [2:0] P2,
   output logic       DONE,
   output logic [1:0] WIN
);

   state_e              state_q, state_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic                ptr_q, ptr_d;          // 0 = ship 1 has priority
   logic                shooter_q, shooter_d;  // 0 = ship 1 is shooting
   logic [1:0]          spos_q, spos_d;
   logic                shot1_q, shot1_d, shot2_q, shot2_d;
   logic                hit1_q, hit1_d, hit2_q, hit2_d;
   logic                a1_q, a1_d, a2_q, a2_d;
   logic [LIFE_W-1:0]   p1_q, p1_d, p2_q, p2_d;
   logic                done_q, done_d;
   logic [1:0]          win_q, win_d;

   logic                pend1, pend2;
   logic                grant1_c, grant2_c;
   logic                fire_en_c;
   logic [1:0]          tgt_pos_c;
   logic                hit_c;
   logic                lose_c;

   assign fire_en_c = (state_q != ST_IDLE) && (state_q != ST_OVER);
   assign tgt_pos_c = shooter_q ? POS1 : POS2;
   assign hit_c     = pos_match(spos_q, tgt_pos_c);
   assign lose_c    = hit_c && (shooter_q ? (!a1_q && (p1_q <= LIFE_W'(1)))
                                          : (!a2_q && (p2_q <= LIFE_W'(1))));

   fire_latch u_fire1 (
      .clk     (CLK),
      .rst     (RST),
      .fire    (FIRE1),
      .en      (fire_en_c),
      .clr     (grant1_c),
      .pending (pend1)
   );

   fire_latch u_fire2 (
      .clk     (CLK),
      .rst     (RST),
      .fire    (FIRE2),
      .en      (fire_en_c),
      .clr     (grant2_c),
      .pending (pend2)
   );

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      ptr_d     = ptr_q;
      shooter_d = shooter_q;
      spos_d    = spos_q;
      shot1_d   = shot1_q;
      shot2_d   = shot2_q;
      hit1_d    = 1'b0;
      hit2_d    = 1'b0;
      a1_d      = a1_q;
      a2_d      = a2_q;
      p1_d      = p1_q;
      p2_d      = p2_q;
      done_d    = done_q;
      win_d     = win_q;
      grant1_c  = 1'b0;
      grant2_c  = 1'b0;

      case (state_q)
         ST_IDLE, ST_OVER: begin
            if (START) begin
               p1_d    = LIFE_W'(LIVES);
               p2_d    = LIFE_W'(LIVES);
               a1_d    = ARM_EN;
               a2_d    = ARM_EN;
               ptr_d   = 1'b0;
               done_d  = 1'b0;
               win_d   = WIN_NONE;
               state_d = ST_READY;
            end
         end
         ST_READY: begin
            // Pointer only matters when both ships are pending.
            if (pend1 && (!pend2 || !ptr_q)) begin
               grant1_c = 1'b1;
            end else if (pend2) begin
               grant2_c = 1'b1;
            end
            if (grant1_c || grant2_c) begin
               shooter_d = grant2_c;
               spos_d    = grant2_c ? POS2 : POS1;
               shot1_d   = grant1_c;
               shot2_d   = grant2_c;
               ptr_d     = !grant2_c;
               cnt_d     = CNT_W'(SHOT_CYCLES - 1);
               state_d   = ST_FLIGHT;
            end
         end
         ST_FLIGHT: begin
            if (cnt_q == '0) begin
               state_d = ST_RESOLVE;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         ST_RESOLVE: begin
            shot1_d = 1'b0;
            shot2_d = 1'b0;
            if (hit_c && !shooter_q) begin
               hit2_d = 1'b1;
               if (a2_q)                  a2_d = 1'b0;
               else if (p2_q != '0)       p2_d = p2_q - LIFE_W'(1);
            end
            if (hit_c && shooter_q) begin
               hit1_d = 1'b1;
               if (a1_q)                  a1_d = 1'b0;
               else if (p1_q != '0)       p1_d = p1_q - LIFE_W'(1);
            end
            if (lose_c) begin
               done_d  = 1'b1;
               win_d   = shooter_q ? WIN_S2 : WIN_S1;
               state_d = ST_OVER;
            end else if (COOLDOWN == 0) begin
               state_d = ST_READY;
            end else begin
               cnt_d   = CNT_W'(COOLDOWN);
               state_d = ST_COOL;
            end
         end
         ST_COOL: begin
            // Leave after exactly COOLDOWN cycles here.
            if (cnt_q <= CNT_W'(1)) begin
               cnt_d   = '0;
               state_d = ST_READY;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q   <= ST_IDLE;
         cnt_q     <= '0;
         ptr_q     <= 1'b0;
         shooter_q <= 1'b0;
         spos_q    <= '0;
         shot1_q   <= 1'b0;
         shot2_q   <= 1'b0;
         hit1_q    <= 1'b0;
         hit2_q    <= 1'b0;
         a1_q      <= 1'b0;
         a2_q      <= 1'b0;
         p1_q      <= '0;
         p2_q      <= '0;
         done_q    <= 1'b0;
         win_q     <= WIN_NONE;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         ptr_q     <= ptr_d;
         shooter_q <= shooter_d;
         spos_q    <= spos_d;
         shot1_q   <= shot1_d;
         shot2_q   <= shot2_d;
         hit1_q    <= hit1_d;
         hit2_q    <= hit2_d;
         a1_q      <= a1_d;
         a2_q      <= a2_d;
         p1_q      <= p1_d;
         p2_q      <= p2_d;
         done_q    <= done_d;
         win_q     <= win_d;
      end
   end

   assign SHOT1 = shot1_q;
   assign SHOT2 = shot2_q;
   assign HIT1  = hit1_q;
   assign HIT2  = hit2_q;
   assign A1    = a1_q;
   assign A2    = a2_q;
   assign P1    = p1_q;
   assign P2    = p2_q;
   assign DONE  = done_q;
   assign WIN   = win_q;

endmodule

// File: tb/tb_galaga_shot_sched.sv
// Directed bench for galaga_shot_sched with default parameters (4/2/3).
module tb_galaga_shot_sched;

   localparam int FLY = 5;   // grant sample -> post-resolve sample
   localparam int CD  = 2;   // post-resolve sample -> READY sample

   logic       clk = 1'b0;
   logic       rst, start, arm_en, fire1, fire2;
   logic [1:0] pos1, pos2;
   logic       shot1, shot2, hit1, hit2, a1, a2, done;
   logic [2:0] p1, p2;
   logic [1:0] win;

   int checks   = 0;
   int failures = 0;

   galaga_shot_sched dut (
      .CLK    (clk),
      .RST    (rst),
      .START  (start),
      .ARM_EN (arm_en),
      .FIRE1  (fire1),
      .FIRE2  (fire2),
      .POS1   (pos1),
      .POS2   (pos2),
      .SHOT1  (shot1),
      .SHOT2  (shot2),
      .HIT1   (hit1),
      .HIT2   (hit2),
      .A1     (a1),
      .A2     (a2),
      .P1     (p1),
      .P2     (p2),
      .DONE   (done),
      .WIN    (win)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic reset_start(input logic arm);
      rst = 1'b1; start = 1'b0; fire1 = 1'b0; fire2 = 1'b0;
      ticks(2);
      rst = 1'b0; arm_en = arm; start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; arm_en = 1'b0; fire1 = 1'b0; fire2 = 1'b0;
      pos1 = 2'b00; pos2 = 2'b00;
      ticks(2);
      check("reset_outputs", {shot1, shot2, hit1, hit2, a1, a2, done, win[0]}, 8'h00);
      check("reset_lives", {2'b00, p1, p2}, 8'h00);
      check("reset_win", {6'd0, win}, 8'h00);

      // 1: reset in mid-flight aborts with nothing applied
      reset_start(1'b0);
      check("start_p1", {5'd0, p1}, 8'd3);
      fire1 = 1'b1;
      tick();
      tick();
      check("t1_granted", {7'd0, shot1}, 8'd1);
      tick();
      rst = 1'b1;
      #1;
      check("t1_rst_shot", {7'd0, shot1}, 8'd0);
      check("t1_rst_lives", {2'b00, p1, p2}, 8'h00);
      fire1 = 1'b0;
      tick();
      check("t1_rst_nohit", {6'd0, hit1, hit2}, 8'd0);

      // 2: basic aligned hit, no armor
      reset_start(1'b0);
      pos1 = 2'b00; pos2 = 2'b00;
      fire1 = 1'b1;
      tick();
      check("t2_not_yet", {7'd0, shot1}, 8'd0);
      tick();
      check("t2_grant", {6'd0, shot1, shot2}, 8'b10);
      fire1 = 1'b0;
      for (int i = 0; i < FLY - 1; i++) begin
         tick();
         check("t2_in_flight", {6'd0, shot1, hit2}, 8'b10);
      end
      tick();
      check("t2_hit2", {6'd0, hit1, hit2}, 8'b01);
      check("t2_shot_clr", {7'd0, shot1}, 8'd0);
      check("t2_p2", {5'd0, p2}, 8'd2);
      check("t2_p1", {5'd0, p1}, 8'd3);
      tick();
      check("t2_hit_pulse", {7'd0, hit2}, 8'd0);
      tick();

      // 3: armor absorbs the first hit, the second costs a life
      reset_start(1'b1);
      check("t3_armor_init", {6'd0, a1, a2}, 8'b11);
      fire1 = 1'b1;
      ticks(2);
      fire1 = 1'b0;
      ticks(FLY);
      check("t3_hit_a", {7'd0, hit2}, 8'd1);
      check("t3_armor_gone", {6'd0, a1, a2}, 8'b10);
      check("t3_p2_kept", {5'd0, p2}, 8'd3);
      ticks(CD);
      fire1 = 1'b1;
      ticks(2);
      fire1 = 1'b0;
      ticks(FLY);
      check("t3_hit_b", {7'd0, hit2}, 8'd1);
      check("t3_p2_dec", {5'd0, p2}, 8'd2);
      ticks(CD);

      // 4: target dodges during flight; cooldown latency to next grant
      pos1 = 2'b01; pos2 = 2'b01;
      fire1 = 1'b1;
      ticks(2);
      check("t4_grant", {7'd0, shot1}, 8'd1);
      fire1 = 1'b0;
      pos2 = 2'b10;
      fire2 = 1'b1;
      ticks(FLY);
      check("t4_no_hit", {6'd0, hit1, hit2}, 8'd0);
      check("t4_p2_same", {5'd0, p2}, 8'd2);
      ticks(CD);
      check("t4_ready_nogrant", {7'd0, shot2}, 8'd0);
      tick();
      check("t4_grant2", {6'd0, shot1, shot2}, 8'b01);
      fire2 = 1'b0;
      ticks(FLY);
      check("t4_miss2", {6'd0, hit1, hit2}, 8'd0);
      check("t4_a1_p1", {4'd0, a1, p1}, 8'h0B);
      ticks(CD);

      // 5: simultaneous fire resolved by the round-robin pointer
      reset_start(1'b0);
      pos1 = 2'b01; pos2 = 2'b10;
      start = 1'b1; arm_en = 1'b1;
      tick();
      start = 1'b0;
      check("t5_start_ignored", {6'd0, a1, a2}, 8'd0);
      fire1 = 1'b1; fire2 = 1'b1;
      ticks(2);
      check("t5_pair1_first", {6'd0, shot1, shot2}, 8'b10);
      fire1 = 1'b0; fire2 = 1'b0;
      ticks(FLY + CD);
      check("t5_pair1_wait", {6'd0, shot1, shot2}, 8'b00);
      tick();
      check("t5_pair1_second", {6'd0, shot1, shot2}, 8'b01);
      ticks(FLY + CD);
      fire1 = 1'b1;
      ticks(2);
      check("t5_single", {6'd0, shot1, shot2}, 8'b10);
      fire1 = 1'b0;
      ticks(FLY + CD);
      fire1 = 1'b1; fire2 = 1'b1;
      ticks(2);
      check("t5_pair2_first", {6'd0, shot1, shot2}, 8'b01);
      fire1 = 1'b0; fire2 = 1'b0;
      ticks(FLY + CD + 1);
      check("t5_pair2_second", {6'd0, shot1, shot2}, 8'b10);
      ticks(FLY + CD);

      // 6: ship 2 wins after three aligned hits; OVER holds, START restarts
      reset_start(1'b0);
      pos1 = 2'b00; pos2 = 2'b00;
      for (int k = 1; k <= 3; k++) begin
         fire2 = 1'b1;
         ticks(2);
         fire2 = 1'b0;
         ticks(FLY);
         check("t6_hit1", {7'd0, hit1}, 8'd1);
         check("t6_p1", {5'd0, p1}, 8'(3 - k));
         if (k < 3) ticks(CD);
      end
      check("t6_done", {7'd0, done}, 8'd1);
      check("t6_win", {6'd0, win}, 8'b10);
      fire1 = 1'b1;
      ticks(3);
      check("t6_over_noshot", {6'd0, shot1, shot2}, 8'd0);
      check("t6_over_hold", {3'd0, done, win, 2'b00}, 8'b00011000);
      check("t6_over_p", {2'b00, p1, p2}, {2'b00, 3'd0, 3'd3});
      start = 1'b1;
      tick();
      start = 1'b0;
      check("t6_restart_p", {2'b00, p1, p2}, {2'b00, 3'd3, 3'd3});
      check("t6_restart_done", {5'd0, done, win}, 8'd0);
      ticks(2);
      check("t6_no_stale_pend", {7'd0, shot1}, 8'd0);
      fire1 = 1'b0;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
